// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: size encodings, controller states and alignment check for mem_access_ctrl.
package mem_ctrl_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [2:0] {IDLE, RD, MRG, WR, RESP, ERR} state_t;
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    return (size == 2'b11) || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  assign sh = {off_i, 3'b000};
  always_comb begin
    lane    = word_i >> sh;
    load_o  = size_i == SZ_BYTE ? {{24{sext_i & lane[7]}}, lane[7:0]} :
              size_i == SZ_HALF ? {{16{sext_i & lane[15]}}, lane[15:0]} : word_i;
    mask    = (size_i == SZ_BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merge_o = size_i == SZ_WORD ? wdata_i : (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store sequencer with RMW for a word-addressed memory.
// Define MEM_ACCESS_CNT_EN to add saturating rd_cnt/wr_cnt access counters.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);
  state_t      state_q, state_d;
  logic        we_q, sext_q;
  logic [1:0]  size_q, off_q, cnt_q, cnt_d;
  logic [31:0] wdata_q, word_q, word_d, load_w, merge_w;
  logic        accept;
  assign accept = req_valid && state_q == IDLE;
  mem_lane_unit u_lane (
    .size_i (size_q),
    .sext_i (sext_q),
    .off_i  (off_q),
    .word_i (word_q),
    .wdata_i(wdata_q),
    .load_o (load_w),
    .merge_o(merge_w)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 2'(RD_LAT - 1);
        if (req_valid)
          state_d = is_misaligned(req_size, req_addr[1:0]) ? ERR :
                    (!req_we || req_size != SZ_WORD) ? RD : WR;
      end
      RD: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          word_d  = M_R_Data;
          state_d = we_q ? MRG : RESP;
        end
      end
      MRG: begin
        word_d  = merge_w;
        state_d = WR;
      end
      WR:        state_d = RESP;
      RESP, ERR: state_d = rsp_ready ? IDLE : state_q;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      Mem_Read  <= 1'b0;
      Mem_Write <= 1'b0;
      Mem_Addr  <= '0;
      M_W_Data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      Mem_Read  <= state_d == RD;
      Mem_Write <= state_d == WR;
      if (accept) begin
        we_q     <= req_we;
        sext_q   <= req_sext;
        size_q   <= req_size;
        off_q    <= req_addr[1:0];
        wdata_q  <= req_wdata;
        Mem_Addr <= req_addr[ADDR_W+1:2];
      end
      // word stores go straight from IDLE, sub-word stores carry the merged word out of MRG
      if (state_d == WR) M_W_Data <= state_q == IDLE ? req_wdata : merge_w;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP || state_q == ERR;
  assign rsp_err   = state_q == ERR;
  assign rsp_rdata = (state_q == RESP && !we_q) ? load_w : '0;
`ifdef MEM_ACCESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (state_q == RD && cnt_q == 2'd0 && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if (state_q == WR && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store checks against a word-array reference model.
module tb_mem_access_ctrl;
  localparam int RD_LAT = 1;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_sext;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        Mem_Read, Mem_Write;
  logic [7:0]  Mem_Addr;
  logic [31:0] M_W_Data, M_R_Data;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int checks = 0, errors = 0;
  int rdc, wrc, exp_rdb = 0, exp_wrb = 0;
  logic [31:0] wr_word;
  logic [7:0]  exp_wa;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_sext(req_sext), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
    .M_W_Data(M_W_Data), .M_R_Data(M_R_Data)
`ifdef MEM_ACCESS_CNT_EN
    , .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
`endif
  );

  assign M_R_Data = mem[Mem_Addr];
  always @(posedge clk) if (Mem_Write) mem[Mem_Addr] <= M_W_Data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("strobe_excl", 32'(Mem_Read && Mem_Write), 32'd0);
    if (Mem_Read) rdc++;
    if (Mem_Write) begin
      wrc++;
      wr_word = M_W_Data;
    end
    if (Mem_Read || Mem_Write) chk("mem_addr", 32'(Mem_Addr), 32'(exp_wa));
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_read", 32'(Mem_Read), 32'd0);
    chk("rst_mem_write", 32'(Mem_Write), 32'd0);
    chk("rst_mem_addr", 32'(Mem_Addr), 32'd0);
    chk("rst_m_w_data", M_W_Data, 32'd0);
  endtask

  // Issues one request, checks it against the reference model, returns the response.
  task automatic xact(input logic we, input logic [1:0] size, input logic sext,
                      input logic [9:0] addr, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err);
    logic        mis;
    logic [7:0]  wi;
    logic [4:0]  sh;
    logic [31:0] w, v, mask, nw, exp_rd;
    int lat, exp_lat, exp_rdc, exp_wrc;
    mis = size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    wi = addr[9:2];
    sh = 5'(addr[1:0] * 8);
    w = ref_mem[wi];
    exp_rd = 32'd0; exp_rdc = 0; exp_wrc = 0; nw = w;
    if (mis) exp_lat = 1;
    else if (!we) begin
      v = w >> sh;
      exp_rd = size == 2'd0 ? ((sext && v[7]) ? (v & 32'hFF) | 32'hFFFF_FF00 : v & 32'hFF) :
               size == 2'd1 ? ((sext && v[15]) ? (v & 32'hFFFF) | 32'hFFFF_0000 : v & 32'hFFFF) : w;
      exp_lat = 1 + RD_LAT; exp_rdc = RD_LAT;
    end else begin
      mask = (size == 2'd0 ? 32'hFF : 32'hFFFF) << sh;
      nw = size == 2'd2 ? wdata : (w & ~mask) | ((wdata << sh) & mask);
      exp_lat = size == 2'd2 ? 2 : RD_LAT + 3;
      exp_rdc = size == 2'd2 ? 0 : RD_LAT;
      exp_wrc = 1;
    end
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_size = size; req_sext = sext;
    req_addr = addr; req_wdata = wdata;
    exp_wa = wi; rdc = 0; wrc = 0; wr_word = 32'hX;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!rsp_valid && lat < 40);
    chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err = rsp_err;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_err", 32'(err), 32'(mis));
    chk("rsp_rdata", rdata, exp_rd);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, rdata);
      chk("bp_err", 32'(rsp_err), 32'(err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("rsp_done", 32'(rsp_valid), 32'd0);
    chk("read_cycles", 32'(rdc), 32'(exp_rdc));
    chk("write_cycles", 32'(wrc), 32'(exp_wrc));
    if (exp_wrc != 0) chk("write_data", wr_word, nw);
    if (exp_rdc != 0) exp_rdb++;
    exp_wrb += exp_wrc;
    ref_mem[wi] = nw;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int n;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sext = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1; exp_wa = '0;
    tick(); tick();
    chk_reset_vals();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) xact(1'b1, 2'd2, 1'b0, 10'(i * 4), $urandom, 0, rd, er);
    xact(1'b1, 2'd2, 1'b0, 10'h004, 32'h0000_0010, 0, rd, er);
    chk("ws_addr1_data", wr_word, 32'h0000_0010);
    xact(1'b0, 2'd2, 1'b0, 10'h004, 32'd0, 0, rd, er);
    chk("wl_data", rd, 32'h0000_0010);
    chk("wl_err", 32'(er), 32'd0);
    xact(1'b1, 2'd2, 1'b0, 10'h000, 32'h1234_5678, 0, rd, er);
    xact(1'b1, 2'd0, 1'b0, 10'h002, 32'h0000_00AB, 0, rd, er);
    chk("rmw_wdata", wr_word, 32'h12AB_5678);
    xact(1'b0, 2'd2, 1'b0, 10'h000, 32'd0, 0, rd, er);
    chk("rmw_load", rd, 32'h12AB_5678);
    xact(1'b1, 2'd2, 1'b0, 10'h000, 32'h0000_80FF, 0, rd, er);
    xact(1'b0, 2'd1, 1'b1, 10'h000, 32'd0, 0, rd, er);
    chk("half_sext", rd, 32'hFFFF_80FF);
    xact(1'b0, 2'd1, 1'b0, 10'h000, 32'd0, 0, rd, er);
    chk("half_zext", rd, 32'h0000_80FF);
    xact(1'b0, 2'd0, 1'b1, 10'h001, 32'd0, 0, rd, er);
    chk("byte_sext", rd, 32'hFFFF_FF80);
    xact(1'b0, 2'd2, 1'b0, 10'h006, 32'd0, 0, rd, er);
    chk("mis_word_err", 32'(er), 32'd1);
    xact(1'b1, 2'd1, 1'b0, 10'h003, 32'h0000_BEEF, 0, rd, er);
    chk("mis_half_err", 32'(er), 32'd1);
    xact(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hCAFE_F00D, 0, rd, er);
    xact(1'b0, 2'd2, 1'b0, 10'h3FC, 32'd0, 0, rd, er);
    chk("word255", rd, 32'hCAFE_F00D);
    xact(1'b0, 2'd2, 1'b0, 10'h004, 32'd0, 5, rd, er);
    for (int i = 0; i < 80; i++)
      xact(1'($urandom), 2'($urandom), 1'($urandom), 10'($urandom_range(0, 63)), $urandom,
           ($urandom_range(0, 7) == 0) ? 2 : 0, rd, er);
`ifdef MEM_ACCESS_CNT_EN
    chk("rd_cnt", 32'(rd_cnt), 32'(exp_rdb));
    chk("wr_cnt", 32'(wr_cnt), 32'(exp_wrb));
`endif
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_sext = 1'b0;
    req_addr = 10'h008; req_wdata = 32'hDEAD_BEEF; exp_wa = 8'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!Mem_Write && n < 10);
    chk("wr_reached", 32'(Mem_Write), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_mw", 32'(Mem_Write), 32'd0);
    chk_reset_vals();
    exp_rdb = 0; exp_wrb = 0;
    tick();
    rst = 1'b0;
    tick();
    xact(1'b0, 2'd2, 1'b0, 10'h008, 32'd0, 0, rd, er);
    chk("abandoned_write", rd, ref_mem[2]);
`ifdef MEM_ACCESS_CNT_EN
    chk("rd_cnt_post", 32'(rd_cnt), 32'(exp_rdb));
    chk("wr_cnt_post", 32'(wr_cnt), 32'(exp_wrb));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
